// File: rtl/cnn16_mem_pkg.sv
// Shared widths, arbiter state encoding and owner codes for the cnn16 memory arbiter.
package cnn16_mem_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORE = 2'd1,
      LOAD = 2'd2
   } arb_state_e;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_LOAD = 1'b1;

   // Tie-break: the requester not served last wins; a lone requester always wins.
   function automatic logic pick_owner(input logic c_elig, input logic l_elig,
                                       input logic load_first);
      logic win;
      win = l_elig ? OWN_LOAD : OWN_CORE;
      if (c_elig && l_elig) win = load_first ? OWN_LOAD : OWN_CORE;
      return win;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Stall counter for the memory arbiter: expired flags the LIMIT-th enabled cycle.
module mem_arb_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count;

   assign expired = enable && (count == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (core / loader) round-robin arbiter for one shared memory port.
// Optional stall timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
   import cnn16_mem_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_ack,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_ack,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic              busy,
   output logic              owner,
   output logic              timeout_err
);

   arb_state_e state;
   logic       load_first;
   logic       c_elig;
   logic       l_elig;
   logic       winner;
   logic       tmo_hit;

   // A requester whose ack is showing this cycle sits out one arbitration round.
   assign c_elig = c_req && !c_ack;
   assign l_elig = l_req && !l_ack;
   assign winner = pick_owner(c_elig, l_elig, load_first);

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .enable  (state != IDLE),
      .expired (tmo_hit)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign tmo_hit        = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         load_first  <= 1'b0;
         owner       <= OWN_CORE;
         m_en        <= 1'b0;
         m_we        <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         busy        <= 1'b0;
         c_ack       <= 1'b0;
         l_ack       <= 1'b0;
         c_rdata     <= '0;
         l_rdata     <= '0;
         timeout_err <= 1'b0;
      end else begin
         c_ack       <= 1'b0;
         l_ack       <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (c_elig || l_elig) begin
                  state      <= (winner == OWN_LOAD) ? LOAD : CORE;
                  owner      <= winner;
                  load_first <= (winner == OWN_CORE);
                  m_en       <= 1'b1;
                  busy       <= 1'b1;
                  m_we       <= (winner == OWN_LOAD) ? l_we    : c_we;
                  m_addr     <= (winner == OWN_LOAD) ? l_addr  : c_addr;
                  m_wdata    <= (winner == OWN_LOAD) ? l_wdata : c_wdata;
               end
            end
            CORE, LOAD: begin
               // m_ready wins over an expiry landing on the same edge.
               if (m_ready || tmo_hit) begin
                  state       <= IDLE;
                  m_en        <= 1'b0;
                  busy        <= 1'b0;
                  timeout_err <= !m_ready;
                  if (state == CORE) begin
                     c_ack <= 1'b1;
                     if (m_ready && !m_we) c_rdata <= m_rdata;
                  end else begin
                     l_ack <= 1'b1;
                     if (m_ready && !m_we) l_rdata <= m_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus directed multi-cycle sequences, scoreboard-checked.
module tb_mem_arbiter;
   import cnn16_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        c_req = 1'b0, c_we = 1'b0;
   logic [11:0] c_addr = '0;
   logic [15:0] c_wdata = '0;
   logic [15:0] c_rdata;
   logic        c_ack;
   logic        l_req = 1'b0, l_we = 1'b0;
   logic [11:0] l_addr = '0;
   logic [15:0] l_wdata = '0;
   logic [15:0] l_rdata;
   logic        l_ack;
   logic        m_en, m_we;
   logic [11:0] m_addr;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata = '0;
   logic        m_ready = 1'b0;
   logic        busy, owner, timeout_err;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_rdata(l_rdata), .l_ack(l_ack),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready),
      .busy(busy), .owner(owner), .timeout_err(timeout_err)
   );

   typedef struct {
      logic        owner;
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        tmo;
   } exp_t;

   typedef struct {
      logic        c_req;
      logic        c_we;
      logic [11:0] c_addr;
      logic [15:0] c_wdata;
      logic        l_req;
      logic        l_we;
      logic [11:0] l_addr;
      logic [15:0] l_wdata;
      int          lat;
      logic        exp_owner;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[10];
   int          checks = 0;
   int          errors = 0;
   int          en_cnt = 0;
   int          last_en_len = 0;
   int          lat = 0;
   logic        stray = 1'b0;
   logic [15:0] c_exp = '0;
   logic [15:0] l_exp = '0;

   // Memory contents as seen by the bench; address 0x010 reads 0xA5A5.
   function automatic logic [15:0] mem_model(input logic [11:0] a);
      return 16'hA5A5 ^ {4'h0, a} ^ 16'h0010;
   endfunction

   function automatic exp_t make_exp(input logic own, input logic we, input logic [11:0] a,
                                     input logic [15:0] wd, input logic tmo);
      exp_t e;
      e.owner = own; e.we = we; e.addr = a; e.wdata = wd;
      e.rdata = mem_model(a); e.tmo = tmo;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: sample just after the edge, score outputs, then drive the memory responder.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      if (m_en) begin
         en_cnt++;
         check("grant_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0)
            check("m_port", {owner, m_we, m_addr, m_wdata, busy},
                  {sb[0].owner, sb[0].we, sb[0].addr, sb[0].wdata, 1'b1});
      end else begin
         if (en_cnt != 0) last_en_len = en_cnt;
         en_cnt = 0;
         check("idle_busy", busy, 1'b0);
      end
      if (c_ack || l_ack) begin
         check("ack_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ack_lines", {c_ack, l_ack}, e.owner ? 2'b01 : 2'b10);
            check("ack_owner", owner, e.owner);
            check("timeout_err", timeout_err, e.tmo);
            if (!e.we && !e.tmo) begin
               if (e.owner == OWN_LOAD) l_exp = e.rdata;
               else c_exp = e.rdata;
            end
         end
      end else begin
         check("timeout_err_idle", timeout_err, 1'b0);
      end
      check("c_rdata", c_rdata, c_exp);
      check("l_rdata", l_rdata, l_exp);
      if (m_en) begin
         m_ready = (lat != 0) && (en_cnt == lat);
         m_rdata = m_ready ? mem_model(m_addr) : 16'hDEAD;
      end else begin
         m_ready = stray;
         m_rdata = 16'hBEEF;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check("drained", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   // Requests stay high until every queued transaction has acked.
   task automatic hold_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      c_req = 1'b0;
      l_req = 1'b0;
      check("hold_drained", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic wait_grant();
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!m_en && n < 10);
      check("grant_seen", m_en, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
      l_req = v.l_req; l_we = v.l_we; l_addr = v.l_addr; l_wdata = v.l_wdata;
      lat = v.lat;
      if (v.exp_owner == OWN_LOAD) sb.push_back(make_exp(OWN_LOAD, v.l_we, v.l_addr, v.l_wdata, 1'b0));
      else sb.push_back(make_exp(OWN_CORE, v.c_we, v.c_addr, v.c_wdata, 1'b0));
      wait_grant();
      // Drop requests and scramble the request buses while the transfer is in flight.
      c_req = 1'b0; l_req = 1'b0;
      c_addr = 12'($urandom); c_wdata = 16'($urandom); c_we = 1'($urandom);
      l_addr = 12'($urandom); l_wdata = 16'($urandom); l_we = 1'($urandom);
      drain(40);
   endtask

   // Called just after a rising edge; asserts reset mid-cycle and checks outputs before the next edge.
   task automatic reset_pulse(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check({tag, "_outputs"}, {m_en, m_we, m_addr, m_wdata, busy, owner, c_ack, l_ack, timeout_err}, 64'd0);
      check({tag, "_rdata"}, {c_rdata, l_rdata}, 64'd0);
      sb.delete();
      c_exp = '0; l_exp = '0; en_cnt = 0; lat = 0;
      c_req = 1'b0; l_req = 1'b0; m_ready = 1'b0;
      #3;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'hFFF, 16'h1234, 5, OWN_LOAD};
      vecs[1] = '{1'b1, 1'b0, 12'h123, 16'h0000, 1'b1, 1'b0, 12'h456, 16'h0000, 2, OWN_CORE};
      vecs[2] = '{1'b1, 1'b1, 12'h200, 16'hBEEF, 1'b1, 1'b0, 12'h3A0, 16'h0000, 3, OWN_LOAD};
      vecs[3] = '{1'b1, 1'b0, 12'h0AB, 16'h0000, 1'b1, 1'b1, 12'h001, 16'hCAFE, 1, OWN_CORE};
      vecs[4] = '{1'b1, 1'b1, 12'h7FF, 16'h5555, 1'b0, 1'b0, 12'h000, 16'h0000, 2, OWN_CORE};
      vecs[5] = '{1'b1, 1'b0, 12'h800, 16'h0000, 1'b1, 1'b0, 12'h000, 16'h0000, 4, OWN_LOAD};
      vecs[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hABC, 16'h0000, 1, OWN_LOAD};
      vecs[7] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b1, 1'b1, 12'h111, 16'h0F0F, 1, OWN_CORE};
      vecs[8] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h222, 16'h7777, 2, OWN_LOAD};
      vecs[9] = '{1'b1, 1'b0, 12'h333, 16'h0000, 1'b1, 1'b0, 12'h444, 16'h0000, 1, OWN_CORE};

      // Reset state while rst is held low.
      #13;
      check("reset_outputs", {m_en, m_we, m_addr, m_wdata, busy, owner, c_ack, l_ack, timeout_err}, 64'd0);
      check("reset_rdata", {c_rdata, l_rdata}, 64'd0);
      #9;
      rst = 1'b1;

      // Stray m_ready in IDLE must not start or complete anything.
      stray = 1'b1;
      repeat (3) cycle();
      stray = 1'b0;
      cycle();
      check("stray_idle", {busy, m_en, c_ack, l_ack}, 4'b0000);

      // Minimum-latency core read of 0x010.
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wdata = 16'h0000; lat = 1;
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h010, 16'h0000, 1'b0));
      cycle();
      check("lat_m_en", m_en, 1'b1);
      c_req = 1'b0;
      cycle();
      check("lat_c_ack", c_ack, 1'b1);
      check("lat_en_len", 64'(last_en_len), 64'd1);
      check("lat_c_rdata", c_rdata, 16'hA5A5);
      cycle();
      check("lat_ack_pulse", {c_ack, m_en}, 2'b00);
      check("lat_drained", 64'(sb.size()), 64'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      check("write_len", 64'(last_en_len), 64'd2);

      // Reset while the loader waits on a memory that never answers.
      l_req = 1'b1; l_we = 1'b0; l_addr = 12'h321; lat = 0;
      sb.push_back(make_exp(OWN_LOAD, 1'b0, 12'h321, l_wdata, 1'b0));
      wait_grant();
      l_req = 1'b0;
      cycle();
      cycle();
      check("pre_reset_owner", {owner, busy}, 2'b11);
      reset_pulse("midrst");
      repeat (3) cycle();
      check("post_reset_idle", {busy, m_en}, 2'b00);

      // Both requesters held: core first, then strict alternation with no double issue.
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h0C0;
      l_req = 1'b1; l_we = 1'b0; l_addr = 12'h0D0; lat = 1;
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0C0, c_wdata, 1'b0));
      sb.push_back(make_exp(OWN_LOAD, 1'b0, 12'h0D0, l_wdata, 1'b0));
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0C0, c_wdata, 1'b0));
      sb.push_back(make_exp(OWN_LOAD, 1'b0, 12'h0D0, l_wdata, 1'b0));
      hold_drain(40);
      repeat (3) cycle();

      // A lone held request re-issues once its ack cycle has passed.
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h0E0; lat = 2;
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0E0, c_wdata, 1'b0));
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0E0, c_wdata, 1'b0));
      hold_drain(40);
      repeat (2) cycle();

      // Memory never ready for a core read.
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h0F0; lat = 0;
`ifdef MEM_ARB_TIMEOUT_EN
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0F0, c_wdata, 1'b1));
      wait_grant();
      c_req = 1'b0;
      drain(30);
      check("timeout_len", 64'(last_en_len), 64'd8);
`else
      sb.push_back(make_exp(OWN_CORE, 1'b0, 12'h0F0, c_wdata, 1'b0));
      wait_grant();
      c_req = 1'b0;
      repeat (20) cycle();
      check("stall_busy", {busy, m_en, c_ack}, 3'b110);
      lat = en_cnt + 1;
      drain(10);
`endif

      // Last grant went to the core; a reset must restore core-first priority.
      cycle();
      reset_pulse("idlerst");
      cycle();
      run_vec(vecs[9]);
      repeat (2) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
